// File: rtl/knn_pkg.sv
// rtl/knn_pkg.sv - shared types for the KNN vote selector
// Holds the FSM state enum, the sorted-list entry layout and the vote-count width helper.
package knn_pkg;

  // Entry fields are sized by KNN_W; the selector's W parameter must equal it.
  localparam int KNN_W = 16;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VOTE    = 2'd1,
    DONE    = 2'd2
  } knn_state_e;

  typedef struct packed {
    logic             valid;
    logic [KNN_W-1:0] distance;
    logic [KNN_W-1:0] dtype;
  } knn_entry_t;

  function automatic int knn_cnt_w(input int k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/knn_sorted_list.sv
// rtl/knn_sorted_list.sv - K-entry ascending insertion list with single-cycle insert
// KNN_SEL_DIST_OUT_EN adds o_head_dist (slot 0 distance, 0 when empty).
module knn_sorted_list
  import knn_pkg::*;
#(
  parameter int K  = 3,
  parameter int W  = KNN_W,
  parameter int SW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_ins,
  input  logic          i_clr,
  input  logic [W-1:0]  i_distance,
  input  logic [W-1:0]  i_type,
  input  logic [SW-1:0] i_sel,
`ifdef KNN_SEL_DIST_OUT_EN
  output logic [W-1:0]  o_head_dist,
`endif
  output logic [W-1:0]  o_sel_type,
  output logic          o_sel_valid
);

  knn_entry_t r_list [K];
  knn_entry_t w_next [K];
  knn_entry_t w_new;
  logic [K-1:0] w_gt;

  assign w_new = '{valid: 1'b1, distance: KNN_W'(i_distance), dtype: KNN_W'(i_type)};

  // Strict compare keeps equal distances ahead of the newcomer; w_gt is 0..0 1..1 along the list.
  for (genvar g = 0; g < K; g++) begin : g_slot
    assign w_gt[g] = !r_list[g].valid || (r_list[g].distance > w_new.distance);
    if (g == 0) begin : g_head
      assign w_next[g] = w_gt[g] ? w_new : r_list[g];
    end else begin : g_tail
      assign w_next[g] = !w_gt[g]     ? r_list[g]   :
                         w_gt[g-1]    ? r_list[g-1] : w_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_list <= '{default: '0};
    end else if (i_clr) begin
      r_list <= '{default: '0};
    end else if (i_ins) begin
      r_list <= w_next;
    end
  end

  assign o_sel_valid = r_list[i_sel].valid;
  assign o_sel_type  = W'(r_list[i_sel].dtype);

`ifdef KNN_SEL_DIST_OUT_EN
  assign o_head_dist = r_list[0].valid ? W'(r_list[0].distance) : '0;
`endif

endmodule

// File: rtl/knn_vote_selector.sv
// rtl/knn_vote_selector.sv - keeps the K nearest pairs of a query and majority-votes their class
// KNN_SEL_DIST_OUT_EN adds out_distance carrying the nearest kept distance.
module knn_vote_selector
  import knn_pkg::*;
#(
  parameter int K = 3,
  parameter int L = 4,
  parameter int W = KNN_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_distance,
  input  logic [W-1:0]           in_type,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_type,
`ifdef KNN_SEL_DIST_OUT_EN
  output logic [W-1:0]           out_distance,
`endif
  output logic [$clog2(K+1)-1:0] out_count
);

  localparam int CW = knn_cnt_w(K);
  localparam int SW = (K > 1) ? $clog2(K) : 1;

  knn_state_e    r_state, w_state_n;
  logic [SW-1:0] r_scan;
  logic [CW-1:0] r_cnt [L];
  logic [CW-1:0] w_cnt_n [L];
  logic [W-1:0]  r_best_type, w_best_type_n;
  logic [CW-1:0] r_best_cnt, w_best_cnt_n;
  logic          w_accept, w_clr, w_last_scan;
  logic          w_sel_valid;
  logic [W-1:0]  w_sel_type;
`ifdef KNN_SEL_DIST_OUT_EN
  logic [W-1:0]  w_head_dist;
  logic [W-1:0]  r_out_dist;
`endif

  knn_sorted_list #(.K(K), .W(W), .SW(SW)) u_list (
    .clk        (clk),
    .rst        (rst),
    .i_ins      (w_accept),
    .i_clr      (w_clr),
    .i_distance (in_distance),
    .i_type     (in_type),
    .i_sel      (r_scan),
`ifdef KNN_SEL_DIST_OUT_EN
    .o_head_dist(w_head_dist),
`endif
    .o_sel_type (w_sel_type),
    .o_sel_valid(w_sel_valid)
  );

  assign w_accept    = in_valid && in_ready;
  assign w_clr       = (r_state == DONE) && out_ready;
  assign w_last_scan = (r_scan == SW'(K - 1));

  always_comb begin
    w_state_n = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      COLLECT: begin
        in_ready = !rst;
        if (w_accept && in_last) w_state_n = VOTE;
      end
      VOTE: begin
        if (w_last_scan) w_state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_n = COLLECT;
      end
      default: w_state_n = COLLECT;
    endcase
  end

  // Out-of-range types match no class and so are skipped; strict '>' gives ties to the earliest leader.
  always_comb begin
    w_cnt_n       = r_cnt;
    w_best_type_n = r_best_type;
    w_best_cnt_n  = r_best_cnt;
    for (int c = 0; c < L; c++) begin
      if (w_sel_valid && (w_sel_type == W'(c))) begin
        w_cnt_n[c] = r_cnt[c] + CW'(1);
        if (w_cnt_n[c] > r_best_cnt) begin
          w_best_cnt_n  = w_cnt_n[c];
          w_best_type_n = W'(c);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= COLLECT;
      r_scan      <= '0;
      r_cnt       <= '{default: '0};
      r_best_type <= '0;
      r_best_cnt  <= '0;
`ifdef KNN_SEL_DIST_OUT_EN
      r_out_dist  <= '0;
`endif
    end else begin
      r_state <= w_state_n;
      if (r_state == VOTE) begin
        r_cnt       <= w_cnt_n;
        r_best_type <= w_best_type_n;
        r_best_cnt  <= w_best_cnt_n;
        r_scan      <= w_last_scan ? '0 : r_scan + SW'(1);
`ifdef KNN_SEL_DIST_OUT_EN
        if (w_last_scan) r_out_dist <= w_head_dist;
`endif
      end else if (w_clr) begin
        r_scan      <= '0;
        r_cnt       <= '{default: '0};
        r_best_type <= '0;
        r_best_cnt  <= '0;
`ifdef KNN_SEL_DIST_OUT_EN
        r_out_dist  <= '0;
`endif
      end
    end
  end

  assign out_type  = r_best_type;
  assign out_count = r_best_cnt;
`ifdef KNN_SEL_DIST_OUT_EN
  assign out_distance = r_out_dist;
`endif

endmodule

// File: tb/tb_knn_vote_selector.sv
// tb/tb_knn_vote_selector.sv - self-checking bench for knn_vote_selector (K=3, L=4, W=16)
// Table vectors, hand-written corner sequences and randomized queries against a rank-based model.
module tb_knn_vote_selector;

  localparam int K  = 3;
  localparam int L  = 4;
  localparam int W  = 16;
  localparam int CW = $clog2(K + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last;
  logic [W-1:0]  in_distance, in_type;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_type;
  logic [CW-1:0] out_count;
`ifdef KNN_SEL_DIST_OUT_EN
  logic [W-1:0]  out_distance;
`endif

  int checks   = 0;
  int failures = 0;

  knn_vote_selector #(.K(K), .L(L), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_distance (in_distance),
    .in_type     (in_type),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_type    (out_type),
`ifdef KNN_SEL_DIST_OUT_EN
    .out_distance(out_distance),
`endif
    .out_count   (out_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input int d, input int t, input bit last);
    int guard = 0;
    in_distance = W'(d);
    in_type     = W'(t);
    in_last     = last;
    in_valid    = 1'b1;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called in the cycle after the last pair was accepted; that cycle counts as latency 1.
  task automatic get_result(input string nm, input int et, input int ec, input int ed, input int hold);
    int lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_latency"}, lat, K + 1);
    for (int h = 0; h < hold; h++) begin
      chk({nm, "_hold_in_ready"}, in_ready, 0);
      tick();
      chk({nm, "_hold_valid"}, out_valid, 1);
    end
    chk({nm, "_type"}, out_type, et);
    chk({nm, "_count"}, out_count, ec);
`ifdef KNN_SEL_DIST_OUT_EN
    chk({nm, "_dist"}, out_distance, ed);
`else
    if (ed < 0) chk({nm, "_dist_arg"}, ed, 0);
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, "_released"}, out_valid, 0);
  endtask

  // A pair's rank is how many pairs beat it (smaller distance, or equal and earlier); rank < K is kept.
  function automatic void ref_model(input int qd[$], input int qt[$],
                                    output int et, output int ec, output int ed);
    int rank [$];
    int cnt [L];
    et = 0;
    ec = 0;
    ed = 0;
    foreach (cnt[c]) cnt[c] = 0;
    for (int i = 0; i < qd.size(); i++) begin
      int r = 0;
      for (int j = 0; j < qd.size(); j++)
        if (qd[j] < qd[i] || (qd[j] == qd[i] && j < i)) r++;
      rank.push_back(r);
    end
    for (int s = 0; s < K; s++)
      for (int i = 0; i < qd.size(); i++)
        if (rank[i] == s) begin
          if (s == 0) ed = qd[i];
          if (qt[i] < L) begin
            cnt[qt[i]]++;
            if (cnt[qt[i]] > ec) begin
              ec = cnt[qt[i]];
              et = qt[i];
            end
          end
        end
  endfunction

  typedef struct {
    int n;
    int d [6];
    int t [6];
    int et;
    int ec;
    int ed;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int qd [$];
    int qt [$];
    int et, ec, ed;

    tbl[0] = '{5, '{10, 5, 7, 3, 20, 0}, '{1, 2, 2, 1, 3, 0}, 2, 2, 3};
    tbl[1] = '{4, '{5, 5, 5, 5, 0, 0},   '{1, 2, 3, 2, 0, 0}, 1, 1, 5};
    tbl[2] = '{1, '{9, 0, 0, 0, 0, 0},   '{3, 0, 0, 0, 0, 0}, 3, 1, 9};
    tbl[3] = '{3, '{1, 2, 4, 0, 0, 0},   '{7, 7, 0, 0, 0, 0}, 0, 1, 1};
    tbl[4] = '{2, '{3, 1, 0, 0, 0, 0},   '{9, 4, 0, 0, 0, 0}, 0, 0, 1};
    tbl[5] = '{5, '{9, 8, 7, 6, 5, 0},   '{0, 0, 1, 2, 3, 0}, 3, 1, 5};
    tbl[6] = '{3, '{4, 4, 4, 0, 0, 0},   '{2, 2, 2, 0, 0, 0}, 2, 3, 4};

    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_distance = '0;
    in_type = '0;
    out_ready = 1'b0;
    repeat (2) tick();
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_type", out_type, 0);
    chk("reset_out_count", out_count, 0);
`ifdef KNN_SEL_DIST_OUT_EN
    chk("reset_out_dist", out_distance, 0);
`endif
    rst = 1'b0;
    #1;
    chk("release_in_ready", in_ready, 1);
    tick();

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < tbl[v].n; i++)
        send(tbl[v].d[i], tbl[v].t[i], i == tbl[v].n - 1);
      get_result($sformatf("vec%0d", v), tbl[v].et, tbl[v].ec, tbl[v].ed, 0);
    end

    // Backpressure in DONE with a pair already offered; it must wait for the handshake.
    send(8, 1, 0);
    send(4, 3, 1);
    for (int w = 0; w < 20 && !out_valid; w++) tick();
    in_distance = 16'd2;
    in_type = 16'd0;
    in_last = 1'b1;
    in_valid = 1'b1;
    for (int h = 0; h < 5; h++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_type", out_type, 3);
      chk("bp_count", out_count, 1);
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_next_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
    get_result("bp_next", 0, 1, 2, 0);

    // Reset during the second VOTE cycle discards the query.
    send(1, 1, 0);
    send(2, 1, 1);
    tick();
    rst = 1'b1;
    #1;
    chk("rstvote_out_valid", out_valid, 0);
    chk("rstvote_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rstvote_release_ready", in_ready, 1);
    chk("rstvote_out_count", out_count, 0);
    send(6, 2, 1);
    get_result("after_rst", 2, 1, 6, 0);

    for (int q = 0; q < 40; q++) begin
      int n = $urandom_range(1, 7);
      qd.delete();
      qt.delete();
      for (int i = 0; i < n; i++) begin
        qd.push_back($urandom_range(0, 12));
        qt.push_back($urandom_range(0, 5));
      end
      ref_model(qd, qt, et, ec, ed);
      for (int i = 0; i < n; i++) begin
        idle($urandom_range(0, 2));
        send(qd[i], qt[i], i == n - 1);
      end
      get_result($sformatf("rand%0d", q), et, ec, ed, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
